// File: rtl/axi_slave_ram.sv
// AXI4 slave backed by a byte-enabled word RAM: 32-bit INCR bursts only,
// independent read and write channels, SLVERR on a misplaced WLAST.
module axi_slave_ram #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic        CLK,
    input  logic        RST,

    input  logic        S_AXI_AWID,
    input  logic [31:0] S_AXI_AWADDR,
    input  logic [7:0]  S_AXI_AWLEN,
    input  logic        S_AXI_AWVALID,
    output logic        S_AXI_AWREADY,

    input  logic [31:0] S_AXI_WDATA,
    input  logic [3:0]  S_AXI_WSTRB,
    input  logic        S_AXI_WLAST,
    input  logic        S_AXI_WVALID,
    output logic        S_AXI_WREADY,

    output logic        S_AXI_BID,
    output logic [1:0]  S_AXI_BRESP,
    output logic        S_AXI_BVALID,
    input  logic        S_AXI_BREADY,

    input  logic        S_AXI_ARID,
    input  logic [31:0] S_AXI_ARADDR,
    input  logic [7:0]  S_AXI_ARLEN,
    input  logic        S_AXI_ARVALID,
    output logic        S_AXI_ARREADY,

    output logic        S_AXI_RID,
    output logic [31:0] S_AXI_RDATA,
    output logic [1:0]  S_AXI_RRESP,
    output logic        S_AXI_RLAST,
    output logic        S_AXI_RVALID,
    input  logic        S_AXI_RREADY
);

    localparam int IW    = ADDR_WIDTH - 2;
    localparam int DEPTH = 1 << IW;
    localparam logic [IW-1:0] IDX_ONE = {{(IW-1){1'b0}}, 1'b1};
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    logic [31:0] mem [0:DEPTH-1];

    // Write channel signals
    w_state_t      w_state, w_state_nxt;
    logic          awready_c, wready_c, bvalid_c;
    logic          aw_hs, w_hs;
    logic          w_last_beat, wlast_err;
    logic          awid_q;
    logic [7:0]    awlen_q;
    logic [7:0]    wcnt_q;
    logic [IW-1:0] widx_q;
    logic          werr_q;

    // Read channel signals
    r_state_t      r_state, r_state_nxt;
    logic          arready_c, rvalid_c;
    logic          ar_hs, r_hs, r_last;
    logic          rd_en;
    logic [IW-1:0] ar_idx, rd_idx;
    logic          rid_q;
    logic [7:0]    arlen_q;
    logic [7:0]    rcnt_q;
    logic [IW-1:0] ridx_q;
    logic [31:0]   rdata_p1;

    // Address bits outside the decoded word index are don't-care (aliasing).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{S_AXI_AWADDR[31:ADDR_WIDTH], S_AXI_AWADDR[1:0],
                                S_AXI_ARADDR[31:ADDR_WIDTH], S_AXI_ARADDR[1:0]};

    // ---------------- write FSM ----------------
    assign w_last_beat = (wcnt_q == awlen_q);
    assign wlast_err   = w_last_beat ? ~S_AXI_WLAST : S_AXI_WLAST;
    assign aw_hs       = S_AXI_AWVALID & awready_c;
    assign w_hs        = S_AXI_WVALID & wready_c;

    always_ff @(posedge CLK) begin
        if (RST) begin
            w_state <= W_IDLE;
        end else begin
            w_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = w_state;
        awready_c   = 1'b0;
        wready_c    = 1'b0;
        bvalid_c    = 1'b0;
        case (w_state)
            W_IDLE: begin
                awready_c = 1'b1;
                if (S_AXI_AWVALID) w_state_nxt = W_DATA;
            end
            W_DATA: begin
                wready_c = 1'b1;
                // Termination follows the captured length; WLAST only feeds BRESP.
                if (S_AXI_WVALID && w_last_beat) w_state_nxt = W_RESP;
            end
            W_RESP: begin
                bvalid_c = 1'b1;
                if (S_AXI_BREADY) w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase
        if (RST) begin
            awready_c = 1'b0;
            wready_c  = 1'b0;
            bvalid_c  = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (aw_hs) begin
            awid_q  <= S_AXI_AWID;
            awlen_q <= S_AXI_AWLEN;
            widx_q  <= S_AXI_AWADDR[ADDR_WIDTH-1:2];
            wcnt_q  <= 8'd0;
            werr_q  <= 1'b0;
        end else if (w_hs) begin
            widx_q  <= widx_q + IDX_ONE;
            wcnt_q  <= wcnt_q + 8'd1;
            werr_q  <= werr_q | wlast_err;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_hs) begin
            for (int b = 0; b < 4; b++) begin
                if (S_AXI_WSTRB[b]) mem[widx_q][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
            end
        end
    end

    assign S_AXI_AWREADY = awready_c;
    assign S_AXI_WREADY  = wready_c;
    assign S_AXI_BVALID  = bvalid_c;
    assign S_AXI_BID     = bvalid_c & awid_q;
    assign S_AXI_BRESP   = !bvalid_c ? RESP_OKAY : (werr_q ? RESP_SLVERR : RESP_OKAY);

    // ---------------- read FSM ----------------
    assign ar_idx = S_AXI_ARADDR[ADDR_WIDTH-1:2];
    assign r_last = (rcnt_q == arlen_q);
    assign ar_hs  = S_AXI_ARVALID & arready_c;
    assign r_hs   = S_AXI_RREADY & rvalid_c;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= r_state_nxt;
        end
    end

    always_comb begin
        r_state_nxt = r_state;
        arready_c   = 1'b0;
        rvalid_c    = 1'b0;
        case (r_state)
            R_IDLE: begin
                arready_c = 1'b1;
                if (S_AXI_ARVALID) r_state_nxt = R_DATA;
            end
            R_DATA: begin
                rvalid_c = 1'b1;
                if (S_AXI_RREADY && r_last) r_state_nxt = R_IDLE;
            end
            default: r_state_nxt = R_IDLE;
        endcase
        if (RST) begin
            arready_c = 1'b0;
            rvalid_c  = 1'b0;
        end
    end

    // The data register only advances on an accepted beat, so it holds under back-pressure.
    assign rd_idx = ar_hs ? ar_idx : ridx_q;
    assign rd_en  = ar_hs | (r_hs & ~r_last);

    always_ff @(posedge CLK) begin
        if (ar_hs) begin
            rid_q   <= S_AXI_ARID;
            arlen_q <= S_AXI_ARLEN;
            rcnt_q  <= 8'd0;
            ridx_q  <= ar_idx + IDX_ONE;
        end else if (r_hs) begin
            rcnt_q  <= rcnt_q + 8'd1;
            ridx_q  <= ridx_q + IDX_ONE;
        end
    end

    // ---- p1: registered RAM read (sees pre-write contents on a same-cycle write) ----
    always_ff @(posedge CLK) begin
        if (rd_en) rdata_p1 <= mem[rd_idx];
    end

    assign S_AXI_ARREADY = arready_c;
    assign S_AXI_RVALID  = rvalid_c;
    assign S_AXI_RDATA   = rdata_p1;
    assign S_AXI_RID     = rvalid_c & rid_q;
    assign S_AXI_RLAST   = rvalid_c & r_last;
    assign S_AXI_RRESP   = RESP_OKAY;

endmodule

// File: tb/tb_axi_slave_ram.sv
// Directed self-checking bench for axi_slave_ram: single/partial/wrap/long bursts,
// back-pressure, WLAST errors, same-cycle read/write and reset mid-burst.
module tb_axi_slave_ram;

    logic        CLK;
    logic        RST;
    logic        S_AXI_AWID;
    logic [31:0] S_AXI_AWADDR;
    logic [7:0]  S_AXI_AWLEN;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WLAST;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic        S_AXI_BID;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic        S_AXI_ARID;
    logic [31:0] S_AXI_ARADDR;
    logic [7:0]  S_AXI_ARLEN;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic        S_AXI_RID;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RLAST;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] wbuf [0:255];
    logic [31:0] rbuf [0:255];

    axi_slave_ram #(.ADDR_WIDTH(12)) dut (
        .CLK(CLK), .RST(RST),
        .S_AXI_AWID(S_AXI_AWID), .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BID(S_AXI_BID), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARID(S_AXI_ARID), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RID(S_AXI_RID), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RLAST(S_AXI_RLAST), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // wl_mode: 0 = WLAST on final beat only, 1 = also on beat 0, 2 = never.
    task automatic write_burst(input logic id, input logic [31:0] addr, input int len,
                               input logic [3:0] strb, input int wl_mode,
                               input logic [1:0] exp_resp);
        int guard;
        @(negedge CLK);
        S_AXI_AWID = id; S_AXI_AWADDR = addr; S_AXI_AWLEN = 8'(len); S_AXI_AWVALID = 1'b1;
        guard = 0;
        while (S_AXI_AWREADY !== 1'b1 && guard < 50) begin @(negedge CLK); guard++; end
        n_checks++;
        if (guard >= 50) begin n_fail++; $display("FAIL aw_timeout addr=%h", addr); end
        @(negedge CLK);
        S_AXI_AWVALID = 1'b0;
        for (int i = 0; i <= len; i++) begin
            S_AXI_WDATA  = wbuf[i];
            S_AXI_WSTRB  = strb;
            S_AXI_WVALID = 1'b1;
            case (wl_mode)
                1:       S_AXI_WLAST = (i == 0) || (i == len);
                2:       S_AXI_WLAST = 1'b0;
                default: S_AXI_WLAST = (i == len);
            endcase
            guard = 0;
            while (S_AXI_WREADY !== 1'b1 && guard < 50) begin @(negedge CLK); guard++; end
            if (guard >= 50) begin
                n_checks++; n_fail++;
                $display("FAIL w_timeout beat=%0d", i);
            end
            @(negedge CLK);
        end
        S_AXI_WVALID = 1'b0;
        S_AXI_WLAST  = 1'b0;
        n_checks++;
        if (S_AXI_BVALID !== 1'b1 || S_AXI_WREADY !== 1'b0) begin
            n_fail++;
            $display("FAIL b_latency bvalid=%b wready=%b required bvalid=1 wready=0",
                     S_AXI_BVALID, S_AXI_WREADY);
        end
        n_checks++;
        if (S_AXI_BRESP !== exp_resp) begin
            n_fail++; $display("FAIL bresp got=%b required=%b", S_AXI_BRESP, exp_resp);
        end
        n_checks++;
        if (S_AXI_BID !== id) begin
            n_fail++; $display("FAIL bid got=%b required=%b", S_AXI_BID, id);
        end
        S_AXI_BREADY = 1'b1;
        @(negedge CLK);
        S_AXI_BREADY = 1'b0;
        n_checks++;
        if (S_AXI_BVALID !== 1'b0 || S_AXI_AWREADY !== 1'b1) begin
            n_fail++;
            $display("FAIL b_done bvalid=%b awready=%b required 0/1", S_AXI_BVALID, S_AXI_AWREADY);
        end
    endtask

    // bp=1 drives RREADY 1,0,0,1,0,0,... and checks RDATA/RLAST are held while low.
    task automatic read_burst(input logic id, input logic [31:0] addr, input int len, input bit bp);
        int guard, beat, cyc;
        logic [31:0] prev_d;
        logic prev_l, prev_hold;
        @(negedge CLK);
        S_AXI_ARID = id; S_AXI_ARADDR = addr; S_AXI_ARLEN = 8'(len); S_AXI_ARVALID = 1'b1;
        guard = 0;
        while (S_AXI_ARREADY !== 1'b1 && guard < 50) begin @(negedge CLK); guard++; end
        n_checks++;
        if (guard >= 50) begin n_fail++; $display("FAIL ar_timeout addr=%h", addr); end
        @(negedge CLK);
        S_AXI_ARVALID = 1'b0;
        beat = 0; cyc = 0; prev_hold = 1'b0; prev_d = '0; prev_l = 1'b0;
        while (beat <= len && cyc < 2000) begin
            if (prev_hold) begin
                n_checks++;
                if (S_AXI_RDATA !== prev_d || S_AXI_RLAST !== prev_l) begin
                    n_fail++;
                    $display("FAIL r_hold beat=%0d rdata=%h rlast=%b required %h/%b",
                             beat, S_AXI_RDATA, S_AXI_RLAST, prev_d, prev_l);
                end
            end
            n_checks++;
            if (S_AXI_RVALID !== 1'b1) begin
                n_fail++; $display("FAIL rvalid beat=%0d got=%b required=1", beat, S_AXI_RVALID);
            end
            n_checks++;
            if (S_AXI_RID !== id) begin
                n_fail++; $display("FAIL rid beat=%0d got=%b required=%b", beat, S_AXI_RID, id);
            end
            S_AXI_RREADY = bp ? (cyc % 3 == 0) : 1'b1;
            if (S_AXI_RREADY) begin
                rbuf[beat] = S_AXI_RDATA;
                n_checks++;
                if (S_AXI_RLAST !== (beat == len)) begin
                    n_fail++;
                    $display("FAIL rlast beat=%0d got=%b required=%b", beat, S_AXI_RLAST, beat == len);
                end
                beat++;
                prev_hold = 1'b0;
            end else begin
                prev_hold = 1'b1;
                prev_d = S_AXI_RDATA;
                prev_l = S_AXI_RLAST;
            end
            @(negedge CLK);
            cyc++;
        end
        S_AXI_RREADY = 1'b0;
        n_checks++;
        if (beat <= len) begin n_fail++; $display("FAIL r_timeout beats=%0d required=%0d", beat, len + 1); end
        n_checks++;
        if (S_AXI_RVALID !== 1'b0 || S_AXI_ARREADY !== 1'b1) begin
            n_fail++;
            $display("FAIL r_done rvalid=%b arready=%b required 0/1", S_AXI_RVALID, S_AXI_ARREADY);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        n_checks++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RLAST} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_handshakes aw=%b w=%b b=%b ar=%b r=%b rl=%b required all 0",
                     S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RLAST);
        end
        n_checks++;
        if ({S_AXI_BRESP, S_AXI_RRESP, S_AXI_BID, S_AXI_RID} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_resp bresp=%b rresp=%b bid=%b rid=%b required 0",
                     S_AXI_BRESP, S_AXI_RRESP, S_AXI_BID, S_AXI_RID);
        end
        RST = 1'b0;
        #1;
        n_checks++;
        if (S_AXI_AWREADY !== 1'b1 || S_AXI_ARREADY !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_exit awready=%b arready=%b required 1/1", S_AXI_AWREADY, S_AXI_ARREADY);
        end
    endtask

    task automatic test_single();
        wbuf[0] = 32'hDEADBEEF;
        write_burst(1'b1, 32'h10, 0, 4'hF, 0, 2'b00);
        read_burst(1'b0, 32'h10, 0, 1'b0);
        n_checks++;
        if (rbuf[0] !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL single_data got=%h required=DEADBEEF", rbuf[0]);
        end
        n_checks++;
        if (S_AXI_RRESP !== 2'b00) begin
            n_fail++; $display("FAIL rresp got=%b required=00", S_AXI_RRESP);
        end
    endtask

    task automatic test_partial_strobe();
        wbuf[0] = 32'hFFFFFFFF;
        write_burst(1'b0, 32'h20, 0, 4'hF, 0, 2'b00);
        wbuf[0] = 32'h11223344;
        write_burst(1'b0, 32'h22, 0, 4'b0101, 0, 2'b00);
        read_burst(1'b0, 32'h20, 0, 1'b0);
        n_checks++;
        if (rbuf[0] !== 32'hFF22FF44) begin
            n_fail++; $display("FAIL partial_strobe got=%h required=FF22FF44", rbuf[0]);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] addrs [0:3];
        addrs[0] = 32'hFF8; addrs[1] = 32'hFFC; addrs[2] = 32'h000; addrs[3] = 32'h004;
        for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
        write_burst(1'b0, 32'hFF8, 3, 4'hF, 0, 2'b00);
        for (int i = 0; i < 4; i++) begin
            read_burst(1'b0, addrs[i], 0, 1'b0);
            n_checks++;
            if (rbuf[0] !== 32'(i + 1)) begin
                n_fail++; $display("FAIL wrap_single addr=%h got=%h required=%0d", addrs[i], rbuf[0], i + 1);
            end
        end
        read_burst(1'b1, 32'hFF8, 3, 1'b0);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rbuf[i] !== 32'(i + 1)) begin
                n_fail++; $display("FAIL wrap_burst beat=%0d got=%h required=%0d", i, rbuf[i], i + 1);
            end
        end
    endtask

    task automatic test_back_pressure();
        for (int i = 0; i < 8; i++) wbuf[i] = 32'h1000 + 32'(i) * 32'h11;
        write_burst(1'b0, 32'h200, 7, 4'hF, 0, 2'b00);
        read_burst(1'b1, 32'h200, 7, 1'b1);
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (rbuf[i] !== 32'h1000 + 32'(i) * 32'h11) begin
                n_fail++; $display("FAIL bp_data beat=%0d got=%h required=%h", i, rbuf[i], 32'h1000 + 32'(i) * 32'h11);
            end
        end
    endtask

    task automatic test_wlast_error();
        wbuf[0] = 32'hA5A5_0000; wbuf[1] = 32'hA5A5_0001;
        write_burst(1'b1, 32'h40, 1, 4'hF, 1, 2'b10);
        read_burst(1'b0, 32'h40, 1, 1'b0);
        n_checks++;
        if (rbuf[0] !== 32'hA5A5_0000 || rbuf[1] !== 32'hA5A5_0001) begin
            n_fail++; $display("FAIL early_wlast_data got=%h,%h required=A5A50000,A5A50001", rbuf[0], rbuf[1]);
        end
        for (int i = 0; i < 3; i++) wbuf[i] = 32'hBB00_0000 + 32'(i);
        write_burst(1'b0, 32'h60, 2, 4'hF, 2, 2'b10);
        read_burst(1'b0, 32'h60, 2, 1'b0);
        n_checks++;
        if (rbuf[2] !== 32'hBB00_0002 || rbuf[0] !== 32'hBB00_0000) begin
            n_fail++; $display("FAIL missing_wlast_data got=%h,%h required=BB000000,BB000002", rbuf[0], rbuf[2]);
        end
    endtask

    task automatic test_same_cycle_rw();
        wbuf[0] = 32'hCAFE0001;
        write_burst(1'b0, 32'h80, 0, 4'hF, 0, 2'b00);
        @(negedge CLK);
        S_AXI_AWID = 1'b0; S_AXI_AWADDR = 32'h80; S_AXI_AWLEN = 8'd0; S_AXI_AWVALID = 1'b1;
        @(negedge CLK);
        S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = 32'h5555AAAA; S_AXI_WSTRB = 4'hF; S_AXI_WLAST = 1'b1; S_AXI_WVALID = 1'b1;
        S_AXI_ARID = 1'b0; S_AXI_ARADDR = 32'h80; S_AXI_ARLEN = 8'd0; S_AXI_ARVALID = 1'b1;
        n_checks++;
        if (S_AXI_WREADY !== 1'b1 || S_AXI_ARREADY !== 1'b1) begin
            n_fail++; $display("FAIL concurrent_ready wready=%b arready=%b required 1/1", S_AXI_WREADY, S_AXI_ARREADY);
        end
        @(negedge CLK);
        S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0; S_AXI_ARVALID = 1'b0;
        n_checks++;
        if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== 32'hCAFE0001) begin
            n_fail++; $display("FAIL read_old_value rvalid=%b rdata=%h required 1/CAFE0001", S_AXI_RVALID, S_AXI_RDATA);
        end
        n_checks++;
        if (S_AXI_BVALID !== 1'b1 || S_AXI_BRESP !== 2'b00) begin
            n_fail++; $display("FAIL concurrent_b bvalid=%b bresp=%b required 1/00", S_AXI_BVALID, S_AXI_BRESP);
        end
        S_AXI_RREADY = 1'b1; S_AXI_BREADY = 1'b1;
        @(negedge CLK);
        S_AXI_RREADY = 1'b0; S_AXI_BREADY = 1'b0;
        read_burst(1'b0, 32'h80, 0, 1'b0);
        n_checks++;
        if (rbuf[0] !== 32'h5555AAAA) begin
            n_fail++; $display("FAIL read_new_value got=%h required=5555AAAA", rbuf[0]);
        end
    endtask

    task automatic test_reset_mid_burst();
        for (int i = 0; i < 8; i++) wbuf[i] = 32'hA0 + 32'(i);
        write_burst(1'b0, 32'h100, 7, 4'hF, 0, 2'b00);
        @(negedge CLK);
        S_AXI_ARID = 1'b1; S_AXI_ARADDR = 32'h100; S_AXI_ARLEN = 8'd7; S_AXI_ARVALID = 1'b1;
        @(negedge CLK);
        S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY = 1'b1;
        repeat (2) @(negedge CLK);
        n_checks++;
        if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== 32'hA2) begin
            n_fail++; $display("FAIL beat2_before_reset rvalid=%b rdata=%h required 1/000000A2", S_AXI_RVALID, S_AXI_RDATA);
        end
        S_AXI_RREADY = 1'b0;
        RST = 1'b1;
        #1;
        n_checks++;
        if (S_AXI_RVALID !== 1'b0 || S_AXI_RLAST !== 1'b0 || S_AXI_ARREADY !== 1'b0 || S_AXI_RID !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset rvalid=%b rlast=%b arready=%b rid=%b required all 0",
                     S_AXI_RVALID, S_AXI_RLAST, S_AXI_ARREADY, S_AXI_RID);
        end
        @(negedge CLK);
        RST = 1'b0;
        #1;
        n_checks++;
        if (S_AXI_ARREADY !== 1'b1 || S_AXI_RVALID !== 1'b0 || S_AXI_AWREADY !== 1'b1) begin
            n_fail++;
            $display("FAIL after_reset arready=%b rvalid=%b awready=%b required 1/0/1",
                     S_AXI_ARREADY, S_AXI_RVALID, S_AXI_AWREADY);
        end
        read_burst(1'b0, 32'h100, 7, 1'b0);
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (rbuf[i] !== 32'hA0 + 32'(i)) begin
                n_fail++; $display("FAIL data_kept beat=%0d got=%h required=%h", i, rbuf[i], 32'hA0 + 32'(i));
            end
        end
    endtask

    task automatic test_long_burst();
        int bad;
        for (int i = 0; i < 256; i++) wbuf[i] = 32'h5A000000 + 32'(i) * 32'd7;
        write_burst(1'b1, 32'h300, 255, 4'hF, 0, 2'b00);
        read_burst(1'b1, 32'h300, 255, 1'b0);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            n_checks++;
            if (rbuf[i] !== 32'h5A000000 + 32'(i) * 32'd7) begin
                n_fail++; bad++;
                if (bad <= 4) $display("FAIL long_data beat=%0d got=%h required=%h", i, rbuf[i], 32'h5A000000 + 32'(i) * 32'd7);
            end
        end
        read_burst(1'b0, 32'h6FC, 0, 1'b0);
        n_checks++;
        if (rbuf[0] !== 32'h5A000000 + 32'd255 * 32'd7) begin
            n_fail++; $display("FAIL long_last_word got=%h required=%h", rbuf[0], 32'h5A000000 + 32'd255 * 32'd7);
        end
    endtask

    initial begin
        RST = 1'b1;
        S_AXI_AWID = 1'b0; S_AXI_AWADDR = '0; S_AXI_AWLEN = '0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WLAST = 1'b0; S_AXI_WVALID = 1'b0;
        S_AXI_BREADY = 1'b0;
        S_AXI_ARID = 1'b0; S_AXI_ARADDR = '0; S_AXI_ARLEN = '0; S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY = 1'b0;
        @(negedge CLK);
        test_reset();
        test_single();
        test_partial_strobe();
        test_wrap();
        test_back_pressure();
        test_wlast_error();
        test_same_cycle_rw();
        test_reset_mid_burst();
        test_long_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_slave_ram.md
AXI_SLAVE_RAM -- requirements
Module: axi_slave_ram

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named CLK and RST.
REQ-002 ADDR_WIDTH, default 12: byte-address bits decoded, giving 2^ADDR_WIDTH bytes of storage.
REQ-003 CLK  input  1  rising-edge clock for all logic.
REQ-004 RST  input  1  synchronous active-high reset.
REQ-005 S_AXI_AWID  input  1  write transaction ID.
REQ-006 S_AXI_AWADDR  input  32  write burst start byte address.
REQ-007 S_AXI_AWLEN  input  8  write beats minus one.
REQ-008 S_AXI_AWVALID / S_AXI_AWREADY  input / output  1 each  AW handshake.
REQ-009 S_AXI_WDATA  input  32  write data.
REQ-010 S_AXI_WSTRB  input  4  byte enables; bit n enables WDATA[8n+7:8n].
REQ-011 S_AXI_WLAST  input  1  master's last-beat marker.
REQ-012 S_AXI_WVALID / S_AXI_WREADY  input / output  1 each  W handshake.
REQ-013 S_AXI_BID  output  1  echo of the captured AWID.
REQ-014 S_AXI_BRESP  output  2  write response: 2'b00 OKAY, 2'b10 SLVERR.
REQ-015 S_AXI_BVALID / S_AXI_BREADY  output / input  1 each  B handshake.
REQ-016 S_AXI_ARID  input  1  read transaction ID.
REQ-017 S_AXI_ARADDR  input  32  read burst start byte address.
REQ-018 S_AXI_ARLEN  input  8  read beats minus one.
REQ-019 S_AXI_ARVALID / S_AXI_ARREADY  input / output  1 each  AR handshake.
REQ-020 S_AXI_RID / S_AXI_RDATA  output  1 / 32  echo of the captured ARID; read data.
REQ-021 S_AXI_RRESP / S_AXI_RLAST  output  2 / 1  always 2'b00; last-beat marker.
REQ-022 S_AXI_RVALID / S_AXI_RREADY  output / input  1 each  R handshake.

Function
REQ-023 Only 32-bit INCR bursts SHALL be supported; SIZE/BURST are not ports, and addresses SHALL use bits [ADDR_WIDTH-1:2] as the word index.
- Address bits [1:0] are ignored.
- Higher bits alias.
REQ-024 The per-beat word index SHALL increment by 1 and wrap modulo 2^(ADDR_WIDTH-2).
REQ-025 The write FSM SHALL have three states; AWREADY=1 only in W_IDLE, WREADY=1 only in W_DATA, BVALID=1 only in W_RESP.
- W_IDLE -> W_DATA on AW handshake: capture AWID, AWADDR and AWLEN; clear the beat counter.
- W_DATA -> W_RESP on the W handshake in which the beat counter equals the captured AWLEN.
- W_RESP -> W_IDLE on BREADY.
REQ-026 Each W handshake SHALL write the enabled bytes at the current word, with no other side effect.
REQ-027 WLAST checking:
- WLAST SHALL be ignored for termination.
- BRESP SHALL be SLVERR if WLAST was high on any non-final beat or low on the final beat; otherwise OKAY.
- Data SHALL be written in either case.
REQ-028 The read FSM SHALL have two states, R_IDLE (ARREADY=1, RVALID=0) and R_DATA (ARREADY=0, RVALID=1).
- AR handshake: capture ARID and ARLEN; RDATA SHALL present mem[ARADDR word] on the next cycle.
REQ-029 While RVALID=1 and RREADY=0, RDATA, RLAST and RID SHALL hold stable.
- On each R handshake, the next beat's data SHALL be presented on the following cycle, so one beat per cycle is sustained while RREADY=1.
REQ-030 RLAST SHALL be 1 exactly on the beat where the beat counter equals ARLEN.
- An R handshake with RLAST=1 SHALL return to R_IDLE, so ARREADY is 1 on the next cycle.
REQ-031 Read and write channels SHALL operate concurrently and independently.
- A read of a word written in the same cycle SHALL return the old value.
REQ-032 AWLEN=0 or ARLEN=0 (single beat) and AWLEN/ARLEN=255 (256 beats) SHALL both be handled, with no lost or extra beats.

Reset
REQ-033 While RST=1, the outputs SHALL be AWREADY=WREADY=BVALID=ARREADY=RVALID=RLAST=0, BRESP=RRESP=2'b00 and BID=RID=0.
- AWREADY and ARREADY SHALL be 1 on the first cycle after RST falls.
REQ-034 RST mid-burst SHALL abort both FSMs to their idle state with no response issued; memory contents SHALL NOT be reset.

Verification
REQ-035 Single write, then single read:
- AW 0x10, WDATA 0xDEADBEEF, WSTRB 4'hF -> BVALID one cycle after the W handshake with BRESP 00.
- AR 0x10 -> RDATA 0xDEADBEEF, RLAST=1.
REQ-036 Partial strobe:
- Write 0x11223344 with WSTRB 4'b0101 over 0xFFFFFFFF at 0x20 -> reading 0x20 returns 0xFF22FF44.
REQ-037 Burst with wrap at ADDR_WIDTH=12:
- Write AWLEN=3 at 0xFF8 with data 1..4 -> reads of 0xFF8, 0xFFC, 0x000 and 0x004 return 1, 2, 3, 4.
- A burst read with ARLEN=3 at 0xFF8 returns the same values with RLAST on beat 4 only.
REQ-038 Back-pressure:
- An 8-beat read with RREADY toggling 1,0,0,1,... -> RDATA is held during the low cycles, no beat is lost, and ARID=1 is echoed on every RID.
REQ-039 WLAST error:
- AWLEN=1 with WLAST=1 on beat 0 -> both beats are written and BRESP=2'b10.
REQ-040 Reset mid-burst:
- RST for 1 cycle during beat 2 of an ARLEN=7 read -> RVALID=0 during reset and ARREADY=1 on the next cycle.
- A new read after reset returns the previously written data.
